// File: rtl/p405s_icu_pkg.sv
// Shared definitions for the ICU fetch path: sequencer states, the reset
// vector and the address offset constants for lines and doublewords.
package p405s_icu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_FILL,
    ST_RESUME
  } fetch_state_e;

  localparam logic [0:31] RESET_VEC_DFLT = 32'hFFFF_FFFC;

  localparam int DW_BYTES      = 8;
  localparam int LINE_BYTES    = 32;
  localparam int DW_OFF_BITS   = 3;   // bits 29:31 select a byte in a doubleword
  localparam int LINE_OFF_BITS = 5;   // bits 27:31 select a byte in a line

  // Clear the byte-in-doubleword offset, bits 29:31.
  function automatic logic [0:31] dw_align(input logic [0:31] addr);
    return {addr[0:28], 3'b000};
  endfunction

endpackage

// File: rtl/p405s_icu_fetch_seq_if.sv
// Core-side and PLB-side handshake signals of the fetch sequencer.
// The slave modport is the sequencer; master is whatever drives it.
interface p405s_icu_fetch_seq_if;
  logic        redirV;
  logic [0:31] redirAddr;
  logic        ifbRdy;
  logic        tagHit;
  logic        plbAck;
  logic        plbDV;
  logic [0:31] va0D;
  logic        va0E1;
  logic        plbReq;
  logic [0:31] plbAddr;
  logic        fillWr;
  logic [0:1]  fillDw;
  logic        fetchV;

  modport master (
    output redirV, redirAddr, ifbRdy, tagHit, plbAck, plbDV,
    input  va0D, va0E1, plbReq, plbAddr, fillWr, fillDw, fetchV
  );

  modport slave (
    input  redirV, redirAddr, ifbRdy, tagHit, plbAck, plbDV,
    output va0D, va0E1, plbReq, plbAddr, fillWr, fillDw, fetchV
  );
endinterface

// File: rtl/p405s_icu_fill_ctr.sv
// Line-fill beat counter: tracks the doubleword index of the current beat,
// starting at the critical doubleword, and flags the last beat of the line.
module p405s_icu_fill_ctr #(
  parameter int BEATS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [0:1] start_dw,
  input  logic       step,
  output logic [0:1] dw,
  output logic       tc
);

  logic [1:0] beat;

  // NOTE: sequential state is written with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dw   <= 2'd0;
      beat <= 2'd0;
    end else if (load) begin
      dw   <= start_dw;
      beat <= 2'd0;
    end else if (step) begin
      dw   <= dw + 2'd1;
      beat <= beat + 2'd1;
    end
  end

  assign tc = (beat == 2'(BEATS - 1));

endmodule

// File: rtl/p405s_icu_fetch_seq.sv
// ICU fetch address sequencer: picks the next VA0 value each cycle and runs
// critical-doubleword-first line fills over the PLB on a tag miss.
module p405s_icu_fetch_seq
  import p405s_icu_pkg::*;
#(
  parameter logic [0:31] RESET_VEC  = RESET_VEC_DFLT,
  parameter int          FILL_BEATS = 4
) (
  input logic                    CB,
  input logic                    resetCore,
  p405s_icu_fetch_seq_if.slave   bus
);

  fetch_state_e state;
  logic [0:31]  cur_va;
  logic [0:31]  miss_va;
  logic [0:31]  pend_addr;
  logic         pend_v;
  logic         plb_req;
  logic [0:31]  seq_va;
  logic         fill_tc;
  logic [0:1]   fill_dw;
  logic         ctr_load;

  assign seq_va   = dw_align(cur_va) + 32'(DW_BYTES);
  assign ctr_load = !resetCore && (state == ST_REQ) && bus.plbAck;

  p405s_icu_fill_ctr #(.BEATS(FILL_BEATS)) u_fill_ctr (
    .clk      (CB),
    .rst      (resetCore),
    .load     (ctr_load),
    .start_dw (miss_va[27:28]),
    .step     (bus.fillWr),
    .dw       (fill_dw),
    .tc       (fill_tc)
  );

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.va0D   = cur_va;
    bus.va0E1  = 1'b0;
    bus.fetchV = 1'b0;
    bus.fillWr = 1'b0;
    if (resetCore) begin
      bus.va0D  = RESET_VEC;
      bus.va0E1 = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          bus.va0D  = RESET_VEC;
          bus.va0E1 = 1'b1;
        end
        ST_FETCH: begin
          if (bus.redirV) begin
            bus.va0D  = dw_align(bus.redirAddr);
            bus.va0E1 = 1'b1;
          end else if (bus.tagHit && bus.ifbRdy) begin
            bus.va0D   = seq_va;
            bus.va0E1  = 1'b1;
            bus.fetchV = 1'b1;
          end
        end
        // A redirect cancels the request only if the ack has not arrived.
        ST_REQ: begin
          if (bus.redirV && !bus.plbAck) begin
            bus.va0D  = dw_align(bus.redirAddr);
            bus.va0E1 = 1'b1;
          end
        end
        ST_FILL: bus.fillWr = bus.plbDV;
        ST_RESUME: begin
          bus.va0D  = pend_v ? dw_align(pend_addr) : miss_va;
          bus.va0E1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CB) begin
    if (resetCore) begin
      state     <= ST_IDLE;
      cur_va    <= RESET_VEC;
      miss_va   <= '0;
      pend_addr <= '0;
      pend_v    <= 1'b0;
      plb_req   <= 1'b0;
    end else begin
      if (bus.va0E1) cur_va <= bus.va0D;
      unique case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (!bus.redirV && !bus.tagHit) begin
            state   <= ST_REQ;
            miss_va <= cur_va;
            plb_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.plbAck) begin
            state   <= ST_FILL;
            plb_req <= 1'b0;
            if (bus.redirV) begin
              pend_v    <= 1'b1;
              pend_addr <= bus.redirAddr;
            end
          end else if (bus.redirV) begin
            state   <= ST_FETCH;
            plb_req <= 1'b0;
          end
        end
        ST_FILL: begin
          if (bus.redirV) begin
            pend_v    <= 1'b1;
            pend_addr <= bus.redirAddr;
          end
          if (bus.plbDV && fill_tc) state <= ST_RESUME;
        end
        ST_RESUME: begin
          pend_v <= 1'b0;
          state  <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.plbReq  = plb_req;
  assign bus.plbAddr = dw_align(miss_va);
  assign bus.fillDw  = fill_dw;

endmodule

// File: tb/tb_p405s_icu_fetch_seq.sv
// Directed bench for the ICU fetch sequencer; models the VA0 register it
// feeds and checks addresses, fill beats and PLB handshakes cycle by cycle.
module tb_p405s_icu_fetch_seq;

  logic        CB = 1'b0;
  logic        resetCore;
  logic [0:31] va0;
  int          n_checks = 0;
  int          n_pass   = 0;

  p405s_icu_fetch_seq_if bus ();

  p405s_icu_fetch_seq dut (
    .CB        (CB),
    .resetCore (resetCore),
    .bus       (bus)
  );

  always #5 CB = ~CB;

  // The VA0 datapath register downstream of the sequencer.
  always_ff @(posedge CB) if (bus.va0E1) va0 <= bus.va0D;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic drive(input logic redir, input logic [31:0] addr, input logic hit,
                       input logic rdy, input logic ack, input logic dv);
    bus.redirV    = redir;
    bus.redirAddr = addr;
    bus.tagHit    = hit;
    bus.ifbRdy    = rdy;
    bus.plbAck    = ack;
    bus.plbDV     = dv;
    #1;
  endtask

  // Four fill beats from the critical doubleword; optional redirect on one beat.
  task automatic run_fill(input logic [1:0] first, input int redir_beat,
                          input logic [31:0] redir_addr);
    logic [1:0] exp_dw;
    for (int i = 0; i < 4; i++) begin
      exp_dw = first + 2'(i);
      drive(i == redir_beat, redir_addr, 1'b0, 1'b0, 1'b0, 1'b1);
      check("fill_wr", 32'(bus.fillWr), 32'd1);
      check("fill_dw", 32'(bus.fillDw), 32'(exp_dw));
      check("fill_e1", 32'(bus.va0E1), 32'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_e1", 32'(bus.va0E1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles with fill-data noise on the bus.
    resetCore = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_va0D",    bus.va0D,           32'hFFFF_FFFC);
      check("rst_va0E1",   32'(bus.va0E1),     32'd1);
      check("rst_plbReq",  32'(bus.plbReq),    32'd0);
      check("rst_fillWr",  32'(bus.fillWr),    32'd0);
      check("rst_fetchV",  32'(bus.fetchV),    32'd0);
      check("rst_fillDw",  32'(bus.fillDw),    32'd0);
      check("rst_plbAddr", bus.plbAddr,        32'h0);
    end
    resetCore = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_va0",  va0,              32'hFFFF_FFFC);
    check("idle_va0D", bus.va0D,         32'hFFFF_FFFC);
    check("idle_e1",   32'(bus.va0E1),   32'd1);
    tick();

    // First hit wraps FFFF_FFFC to 0.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("wrap_fetchV", 32'(bus.fetchV), 32'd1);
    check("wrap_va0D",   bus.va0D,        32'h0);
    tick();
    check("wrap_va0", va0, 32'h0);

    // Redirect beats a hit; then three sequential hits.
    drive(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("redir_fetchV", 32'(bus.fetchV), 32'd0);
    check("redir_e1",     32'(bus.va0E1),  32'd1);
    tick();
    check("redir_va0", va0, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("seq_fetchV", 32'(bus.fetchV), 32'd1);
      tick();
      check("seq_va0", va0, 32'h0000_1008 + 32'(8 * i));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_e1",     32'(bus.va0E1),  32'd0);
    check("hold_fetchV", 32'(bus.fetchV), 32'd0);
    tick();
    check("hold_va0", va0, 32'h0000_1018);

    // Miss at 2018: request, ack after 2 cycles, fill 3,0,1,2, reload.
    drive(1'b1, 32'h0000_2018, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("miss_va0", va0, 32'h0000_2018);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("miss_e1",     32'(bus.va0E1),  32'd0);
    check("miss_plbReq", 32'(bus.plbReq), 32'd0);
    tick();
    check("req_plbReq",  32'(bus.plbReq), 32'd1);
    check("req_plbAddr", bus.plbAddr,     32'h0000_2018);
    check("req_e1",      32'(bus.va0E1),  32'd0);
    tick();
    check("req_hold", 32'(bus.plbReq), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ack_plbReq", 32'(bus.plbReq), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill_plbReq",  32'(bus.plbReq), 32'd0);
    check("fill_first",   32'(bus.fillDw), 32'd3);
    check("fill_gap_wr",  32'(bus.fillWr), 32'd0);
    tick();
    run_fill(2'd3, -1, 32'h0);
    check("resume_va0D", bus.va0D, 32'h0000_2018);
    tick();
    check("resume_va0", va0, 32'h0000_2018);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("refetch_fetchV", 32'(bus.fetchV), 32'd1);
    tick();
    check("refetch_va0", va0, 32'h0000_2020);

    // Redirect to 4004 on beat 2 is held until RESUME.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    run_fill(2'd0, 1, 32'h0000_4004);
    check("pend_va0D", bus.va0D, 32'h0000_4000);
    tick();
    check("pend_va0", va0, 32'h0000_4000);

    // Redirect in REQ before the ack cancels the request.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_5008, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cancel_e1",   32'(bus.va0E1), 32'd1);
    check("cancel_va0D", bus.va0D,       32'h0000_5008);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("cancel_plbReq", 32'(bus.plbReq), 32'd0);
    check("cancel_va0",    va0,             32'h0000_5008);
    check("cancel_fetchV", 32'(bus.fetchV), 32'd1);
    tick();
    check("cancel_seq_va0", va0, 32'h0000_5010);

    // Redirect and ack together: the fill wins, redirect lands in RESUME.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_6010, 1'b0, 1'b0, 1'b1, 1'b0);
    check("race_e1", 32'(bus.va0E1), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("race_plbReq", 32'(bus.plbReq), 32'd0);
    run_fill(2'd2, -1, 32'h0);
    check("race_va0D", bus.va0D, 32'h0000_6010);
    tick();
    check("race_va0", va0, 32'h0000_6010);

    // Reset after beat 1 of a fill that already has a redirect pending.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_wr", 32'(bus.fillWr), 32'd1);
    check("mid_dw", 32'(bus.fillDw), 32'd2);
    tick();
    resetCore = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mrst_fillWr", 32'(bus.fillWr), 32'd0);
    check("mrst_va0D",   bus.va0D,        32'hFFFF_FFFC);
    tick();
    resetCore = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mrst_plbReq", 32'(bus.plbReq), 32'd0);
    check("mrst_fillDw", 32'(bus.fillDw), 32'd0);
    check("mrst_idle_wr", 32'(bus.fillWr), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mrst_va0", va0, 32'hFFFF_FFFC);
    tick();
    check("mrst_req",     32'(bus.plbReq), 32'd1);
    check("mrst_plbAddr", bus.plbAddr,     32'hFFFF_FFF8);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    run_fill(2'd3, -1, 32'h0);
    check("nopend_va0D", bus.va0D, 32'hFFFF_FFFC);
    tick();
    check("nopend_va0", va0, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
